// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for fetch (I) and data (D) requesters.
// One transaction in flight; D has priority, bounded by a streak counter.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_win;

    // D wins unless fetch has waited through a full streak of D grants
    assign d_win = d_req && !(i_req && (streak_q == STREAK_MAX));

    // State and datapath registers; reset drops any in-flight response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state: arbitrate in IDLE, wait for ready in REQ, response in RESP
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = REQ;
                    owner_d = d_win;
                    if (d_win) begin
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        streak_d = i_req ? streak_q + SW'(1) : '0;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_gnt     = mem_req && mem_ready && !owner_q;
    assign d_gnt     = mem_req && mem_ready && owner_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written sequences for starvation guard and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ireq, iaddr, dreq, dwe, daddr, dwdata;
        logic [31:0] rdy, rv, rdata;
        logic [31:0] igt, irv, irdata, dgt, drv, drdata;
        logic [31:0] mreq, mwe, maddr, mwdata, bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".i_gnt"},     32'(i_gnt),    0);
        chk({nm, ".i_rvalid"},  32'(i_rvalid), 0);
        chk({nm, ".i_rdata"},   i_rdata,       0);
        chk({nm, ".d_gnt"},     32'(d_gnt),    0);
        chk({nm, ".d_rvalid"},  32'(d_rvalid), 0);
        chk({nm, ".d_rdata"},   d_rdata,       0);
        chk({nm, ".mem_req"},   32'(mem_req),  0);
        chk({nm, ".mem_we"},    32'(mem_we),   0);
        chk({nm, ".mem_addr"},  mem_addr,      0);
        chk({nm, ".mem_wdata"}, mem_wdata,     0);
        chk({nm, ".busy"},      32'(busy),     0);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        i_req      = v.ireq[0];
        i_addr     = v.iaddr;
        d_req      = v.dreq[0];
        d_we       = v.dwe[0];
        d_addr     = v.daddr;
        d_wdata    = v.dwdata;
        mem_ready  = v.rdy[0];
        mem_rvalid = v.rv[0];
        mem_rdata  = v.rdata;
        #1;
        chk({v.name, ".i_gnt"},     32'(i_gnt),    v.igt);
        chk({v.name, ".i_rvalid"},  32'(i_rvalid), v.irv);
        chk({v.name, ".i_rdata"},   i_rdata,       v.irdata);
        chk({v.name, ".d_gnt"},     32'(d_gnt),    v.dgt);
        chk({v.name, ".d_rvalid"},  32'(d_rvalid), v.drv);
        chk({v.name, ".d_rdata"},   d_rdata,       v.drdata);
        chk({v.name, ".mem_req"},   32'(mem_req),  v.mreq);
        chk({v.name, ".mem_we"},    32'(mem_we),   v.mwe);
        chk({v.name, ".mem_addr"},  mem_addr,      v.maddr);
        chk({v.name, ".mem_wdata"}, mem_wdata,     v.mwdata);
        chk({v.name, ".busy"},      32'(busy),     v.bsy);
    endtask

    // gnt and rvalid pairs must never be high together
    always @(negedge clk) begin
        if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid)) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order;
        string got_order;
        int    n;
        logic  pend;

        // fields: name, ireq iaddr dreq dwe daddr dwdata, rdy rv rdata,
        // igt irv irdata, dgt drv drdata, mreq mwe maddr mwdata busy
        vecs.push_back('{"f0", 1,'h100,0,0,0,0, 1,0,0,
            0,0,0, 0,0,0, 0,0,0,0,0});
        vecs.push_back('{"f1", 1,'h100,0,0,0,0, 1,0,0,
            1,0,0, 0,0,0, 1,0,'h100,0,1});
        vecs.push_back('{"f2", 0,0,0,0,0,0, 1,1,'hDEADBEEF,
            0,0,0, 0,0,0, 0,0,'h100,0,1});
        vecs.push_back('{"f3", 0,0,0,0,0,0, 1,0,0,
            0,1,'hDEADBEEF, 0,0,0, 0,0,'h100,0,0});
        vecs.push_back('{"f4", 0,0,0,0,0,0, 1,0,0,
            0,0,'hDEADBEEF, 0,0,0, 0,0,'h100,0,0});
        vecs.push_back('{"s0", 1,'h104,1,1,'h200,'h12345678, 1,0,0,
            0,0,'hDEADBEEF, 0,0,0, 0,0,'h100,0,0});
        vecs.push_back('{"s1", 1,'h104,1,1,'h200,'h12345678, 1,0,0,
            0,0,'hDEADBEEF, 1,0,0, 1,1,'h200,'h12345678,1});
        vecs.push_back('{"s2", 1,'h104,0,0,0,0, 1,1,'hAAAAAAAA,
            0,0,'hDEADBEEF, 0,0,0, 0,1,'h200,'h12345678,1});
        vecs.push_back('{"s3", 1,'h104,0,0,0,0, 1,0,0,
            0,0,'hDEADBEEF, 0,1,0, 0,1,'h200,'h12345678,0});
        vecs.push_back('{"s4", 1,'h104,0,0,0,0, 1,0,0,
            1,0,'hDEADBEEF, 0,0,0, 1,0,'h104,0,1});
        vecs.push_back('{"s5", 0,0,0,0,0,0, 1,1,'h13,
            0,0,'hDEADBEEF, 0,0,0, 0,0,'h104,0,1});
        vecs.push_back('{"s6", 0,0,0,0,0,0, 1,0,0,
            0,1,'h13, 0,0,0, 0,0,'h104,0,0});
        vecs.push_back('{"b0", 0,0,1,0,'h400,'h55, 0,0,0,
            0,0,'h13, 0,0,0, 0,0,'h104,0,0});
        vecs.push_back('{"b1", 0,0,1,0,'h400,'h55, 0,0,0,
            0,0,'h13, 0,0,0, 1,0,'h400,'h55,1});
        vecs.push_back('{"b2", 0,0,1,0,'h400,'h55, 0,1,'hBAD,
            0,0,'h13, 0,0,0, 1,0,'h400,'h55,1});
        vecs.push_back('{"b3", 0,0,1,0,'h400,'h55, 0,0,0,
            0,0,'h13, 0,0,0, 1,0,'h400,'h55,1});
        vecs.push_back('{"b4", 0,0,1,0,'h400,'h55, 1,0,0,
            0,0,'h13, 1,0,0, 1,0,'h400,'h55,1});
        vecs.push_back('{"b5", 0,0,0,0,0,0, 1,0,0,
            0,0,'h13, 0,0,0, 0,0,'h400,'h55,1});
        vecs.push_back('{"b6", 0,0,0,0,0,0, 1,1,'h7777,
            0,0,'h13, 0,0,0, 0,0,'h400,'h55,1});
        vecs.push_back('{"b7", 0,0,0,0,0,0, 1,0,0,
            0,0,'h13, 0,1,'h7777, 0,0,'h400,'h55,0});
        vecs.push_back('{"b8", 0,0,0,0,0,0, 1,0,0,
            0,0,'h13, 0,0,'h7777, 0,0,'h400,'h55,0});

        reset      = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) apply(vecs[k]);

        // Starvation guard: both requesters held high, memory zero-wait
        exp_order = "DDDDIDDDDI";
        got_order = "";
        n = 0;
        pend = 1'b0;
        @(negedge clk);
        i_req     = 1'b1;
        i_addr    = 32'h700;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h600;
        d_wdata   = 32'h0;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            @(negedge clk);
            mem_rvalid = pend;
            mem_rdata  = 32'(cyc);
            #1;
            if (i_gnt || d_gnt) begin
                got_order = {got_order, i_gnt ? "I" : "D"};
                n++;
            end
            pend = i_gnt || d_gnt;
        end
        chk("starve.count", 32'(n), 32'd10);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("starve.grant%0d", j),
                32'(got_order[j]), 32'(exp_order[j]));
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        i_req      = 1'b0;
        d_req      = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // Reset while waiting in RESP: response must be dropped
        i_req  = 1'b1;
        i_addr = 32'h500;
        @(negedge clk);
        #1;
        chk("rr.i_gnt", 32'(i_gnt), 1);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk("rr.busy_resp", 32'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_zero("rr.async");
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h99999999;
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk_zero("rr.after");
        @(negedge clk);
        #1;
        chk("rr.i_rvalid", 32'(i_rvalid), 0);
        chk("rr.busy", 32'(busy), 0);

        // Normal D read after reset
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        d_wdata = 32'h0;
        @(negedge clk);
        #1;
        chk("rd.d_gnt", 32'(d_gnt), 1);
        chk("rd.mem_req", 32'(mem_req), 1);
        chk("rd.mem_addr", mem_addr, 32'h300);
        @(negedge clk);
        d_req      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        #1;
        chk("rd.d_rvalid_early", 32'(d_rvalid), 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rd.d_rvalid", 32'(d_rvalid), 1);
        chk("rd.d_rdata", d_rdata, 32'hCAFEF00D);
        chk("rd.i_rvalid", 32'(i_rvalid), 0);
        chk("rd.busy", 32'(busy), 0);

        chk("overlap", 32'(overlap), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
